// File: rtl/fp_add_if.sv
// fp_add operand/result bundle.
// Inputs are sampled and outputs driven on the rising edge of the block clock.
interface fp_add_if;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic [31:0] result;
  logic        overflow;
  logic        invalid;

  modport master (
    output in_valid, a, b,
    input  out_valid, result, overflow, invalid
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, result, overflow, invalid
  );
endinterface

// File: rtl/fp_add.sv
// binary32 adder, fully pipelined, latency 3.
// Subnormals are flushed to zero on input and on output.
module fp_add (
  input  logic   clk,
  input  logic   rst_n,
  fp_add_if.slave bus
);

  typedef struct packed {
    logic        sl;
    logic        ss;
    logic [7:0]  el;
    logic [23:0] ml;
    logic [23:0] ms;
    logic [7:0]  diff;
    logic        nan;
    logic        inf;
    logic        inf_s;
  } s1_t;

  typedef struct packed {
    logic        sign;
    logic        zsign;
    logic [7:0]  el;
    logic [27:0] sum;
    logic        nan;
    logic        inf;
    logic        inf_s;
  } s2_t;

  logic        v0, v1, v2;
  logic [31:0] a0, b0;
  s1_t         s1_d, s1_q;
  s2_t         s2_d, s2_q;

  logic        a_z, b_z, a_max, b_max;
  logic        a_nan, b_nan, a_inf, b_inf;
  logic        swap, lw_z, sw_z;
  logic [31:0] lw, sw;
  logic [7:0]  es;

  logic [49:0] wide;
  logic [26:0] sm, lg;

  logic [4:0]  lz;
  logic [26:0] n;
  logic [24:0] m25;
  logic signed [9:0] e_n, e_r;
  logic [22:0] frac;
  logic [31:0] res_d;
  logic        ovf_d, inv_d;

  function automatic logic [4:0] lzc(input logic [26:0] v);
    logic [4:0] c;
    c = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) c = 5'(26 - i);
    return c;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v0            <= 1'b0;
      v1            <= 1'b0;
      v2            <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.overflow  <= 1'b0;
      bus.invalid   <= 1'b0;
    end else begin
      v0            <= bus.in_valid;
      v1            <= v0;
      v2            <= v1;
      bus.out_valid <= v2;
      bus.result    <= v2 ? res_d : '0;
      bus.overflow  <= v2 & ovf_d;
      bus.invalid   <= v2 & inv_d;
    end
  end

  always_ff @(posedge clk) begin
    a0   <= bus.a;
    b0   <= bus.b;
    s1_q <= s1_d;
    s2_q <= s2_d;
  end

  // Unpack, classify, order by magnitude.
  always_comb begin
    a_z   = (a0[30:23] == 8'd0);
    b_z   = (b0[30:23] == 8'd0);
    a_max = &a0[30:23];
    b_max = &b0[30:23];
    a_nan = a_max & (|a0[22:0]);
    b_nan = b_max & (|b0[22:0]);
    a_inf = a_max & ~(|a0[22:0]);
    b_inf = b_max & ~(|b0[22:0]);
    swap  = (b_z ? 31'd0 : b0[30:0]) >
            (a_z ? 31'd0 : a0[30:0]);
    lw    = swap ? b0 : a0;
    sw    = swap ? a0 : b0;
    lw_z  = swap ? b_z : a_z;
    sw_z  = swap ? a_z : b_z;
    es    = sw_z ? 8'd0 : sw[30:23];
    s1_d.sl    = lw[31];
    s1_d.ss    = sw[31];
    s1_d.el    = lw_z ? 8'd0 : lw[30:23];
    s1_d.ml    = lw_z ? 24'd0 : {1'b1, lw[22:0]};
    s1_d.ms    = sw_z ? 24'd0 : {1'b1, sw[22:0]};
    s1_d.diff  = (lw_z ? 8'd0 : lw[30:23]) - es;
    s1_d.nan   = a_nan | b_nan |
                 (a_inf & b_inf & (a0[31] ^ b0[31]));
    s1_d.inf   = a_inf | b_inf;
    s1_d.inf_s = a_inf ? a0[31] : b0[31];
  end

  // Align smaller operand with guard/round/sticky, then add or subtract.
  always_comb begin
    wide = {s1_q.ms, 26'd0} >> s1_q.diff;
    if (s1_q.diff >= 8'd26)
      sm = {26'd0, |s1_q.ms};
    else
      sm = {wide[49:24], |wide[23:0]};
    lg = {s1_q.ml, 3'b000};
    s2_d.sum   = (s1_q.sl ^ s1_q.ss)
               ? {1'b0, lg - sm}
               : {1'b0, lg} + {1'b0, sm};
    s2_d.sign  = s1_q.sl;
    s2_d.zsign = s1_q.sl & s1_q.ss;
    s2_d.el    = s1_q.el;
    s2_d.nan   = s1_q.nan;
    s2_d.inf   = s1_q.inf;
    s2_d.inf_s = s1_q.inf_s;
  end

  // Normalize, round to nearest even, pack.
  always_comb begin
    lz = lzc(s2_q.sum[26:0]);
    if (s2_q.sum[27]) begin
      n   = {s2_q.sum[27:2], |s2_q.sum[1:0]};
      e_n = $signed({2'b00, s2_q.el}) + 10'sd1;
    end else begin
      n   = s2_q.sum[26:0] << lz;
      e_n = $signed({2'b00, s2_q.el}) -
            $signed({5'd0, lz});
    end
    m25  = {1'b0, n[26:3]} +
           {24'd0, n[2] & (n[3] | n[1] | n[0])};
    e_r  = e_n + $signed({9'd0, m25[24]});
    frac = m25[24] ? m25[23:1] : m25[22:0];
    ovf_d = 1'b0;
    inv_d = 1'b0;
    if (s2_q.nan) begin
      res_d = 32'h7FC0_0000;
      inv_d = 1'b1;
    end else if (s2_q.inf) begin
      res_d = {s2_q.inf_s, 8'hFF, 23'd0};
    end else if (s2_q.sum == 28'd0) begin
      res_d = {s2_q.zsign, 31'd0};
    end else if (e_r <= 10'sd0) begin
      res_d = {s2_q.sign, 31'd0};
    end else if (e_r >= 10'sd255) begin
      res_d = {s2_q.sign, 8'hFF, 23'd0};
      ovf_d = 1'b1;
    end else begin
      res_d = {s2_q.sign, e_r[7:0], frac};
    end
  end

endmodule

// File: tb/tb_fp_add.sv
// Bench for fp_add: directed and random operand pairs checked against
// an exact-arithmetic binary32 model with flush-to-zero.
module tb_fp_add;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  fp_add_if bus ();

  fp_add dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic        inv;
    logic        ovf;
    logic [31:0] r;
  } exp_t;

  localparam exp_t IDLE = '0;

  exp_t pipe[$];
  int   errors = 0;
  int   checks = 0;

  logic [31:0] sp [6] = '{32'h7F800000, 32'hFF800000, 32'h7FC00001,
                          32'h00000000, 32'h80000000, 32'h00012345};

  // Exact sum on a wide integer grid (unit 2^-149), then one rounding.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    logic [299:0] one, vx, vy, mag, rem, half, q;
    logic s;
    int ex, ey, p, ee;
    logic nx, ny, ix, iy;
    e   = '0;
    e.v = 1'b1;
    ex  = int'(x[30:23]);
    ey  = int'(y[30:23]);
    nx  = (ex == 255) && (x[22:0] != 0);
    ny  = (ey == 255) && (y[22:0] != 0);
    ix  = (ex == 255) && (x[22:0] == 0);
    iy  = (ey == 255) && (y[22:0] == 0);
    if (nx || ny || (ix && iy && (x[31] != y[31]))) begin
      e.inv = 1'b1;
      e.r   = 32'h7FC00000;
      return e;
    end
    if (ix) begin e.r = {x[31], 8'hFF, 23'd0}; return e; end
    if (iy) begin e.r = {y[31], 8'hFF, 23'd0}; return e; end
    one = 1;
    vx  = (ex == 0) ? '0 : ({276'd0, 1'b1, x[22:0]} << (ex - 1));
    vy  = (ey == 0) ? '0 : ({276'd0, 1'b1, y[22:0]} << (ey - 1));
    if (x[31] == y[31]) begin
      mag = vx + vy; s = x[31];
    end else if (vx >= vy) begin
      mag = vx - vy; s = x[31];
    end else begin
      mag = vy - vx; s = y[31];
    end
    if (mag == 0) begin
      e.r = {x[31] & y[31], 31'd0};
      return e;
    end
    p = 0;
    for (int i = 0; i < 300; i++) if (mag[i]) p = i;
    if (p < 23) begin e.r = {s, 31'd0}; return e; end
    q = mag;
    if (p > 23) begin
      q    = mag >> (p - 23);
      rem  = mag & ((one << (p - 23)) - one);
      half = one << (p - 24);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q[24]) begin q = q >> 1; p++; end
    end
    ee = p - 22;
    if (ee >= 255) begin
      e.ovf = 1'b1;
      e.r   = {s, 8'hFF, 23'd0};
    end else if (ee <= 0) begin
      e.r = {s, 31'd0};
    end else begin
      e.r = {s, 8'(ee), q[22:0]};
    end
    return e;
  endfunction

  function automatic logic [31:0] rnd_norm(input int lo, input int hi);
    return {1'($urandom), 8'($urandom_range(hi, lo)), 23'($urandom)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] x,
                     input logic [31:0] y, input exp_t want);
    exp_t e;
    bus.in_valid = v;
    bus.a        = x;
    bus.b        = y;
    @(posedge clk);
    if (!rst_n) begin
      pipe.delete();
      repeat (3) pipe.push_back(IDLE);
    end else begin
      pipe.push_back(v ? want : IDLE);
    end
    #1;
    if (!rst_n) begin
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", bus.result, 32'd0);
      chk("rst_overflow", 32'(bus.overflow), 32'd0);
      chk("rst_invalid", 32'(bus.invalid), 32'd0);
    end else begin
      e = pipe.pop_front();
      chk("out_valid", 32'(bus.out_valid), 32'(e.v));
      chk("overflow", 32'(bus.overflow), 32'(e.ovf));
      chk("invalid", 32'(bus.invalid), 32'(e.inv));
      if (e.v) chk("result", bus.result, e.r);
    end
  endtask

  task automatic op(input logic [31:0] x, input logic [31:0] y);
    cyc(1'b1, x, y, model(x, y));
  endtask

  task automatic op_k(input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] r, input logic o, input logic i);
    exp_t e;
    e = {1'b1, i, o, r};
    cyc(1'b1, x, y, e);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 32'd0, 32'd0, IDLE);
  endtask

  initial begin
    logic [31:0] x, y;
    int sel;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;

    rst_n = 1'b0;
    cyc(1'b1, 32'h3F800000, 32'h3F800000, IDLE);
    cyc(1'b0, 32'd0, 32'd0, IDLE);
    rst_n = 1'b1;

    op_k(32'h3E800000, 32'h42C80000, 32'h42C88000, 1'b0, 1'b0);
    op_k(32'h42C80000, 32'h42C80000, 32'h43480000, 1'b0, 1'b0);
    op_k(32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0, 1'b0);
    cyc(1'b0, 32'h3F800000, 32'h3F800000, IDLE);
    op_k(32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 1'b0);
    op_k(32'h3F800000, 32'h33800001, 32'h3F800001, 1'b0, 1'b0);
    op_k(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0);
    op_k(32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b1);
    op_k(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1);
    op_k(32'h00000000, 32'h80000000, 32'h00000000, 1'b0, 1'b0);
    op_k(32'h80000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0);
    op_k(32'h80000000, 32'h00000000, 32'h00000000, 1'b0, 1'b0);
    op_k(32'h7F800000, 32'hC2C80000, 32'h7F800000, 1'b0, 1'b0);
    op_k(32'h00400000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0);
    op_k(32'h00800000, 32'h80800001, 32'h80000000, 1'b0, 1'b0);
    op_k(32'h42C80000, 32'h3E800000, 32'h42C88000, 1'b0, 1'b0);
    op_k(32'hBF800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0);
    op_k(32'hFF800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1'b1);
    op_k(32'h3F800001, 32'h7FC00000, 32'h7FC00000, 1'b0, 1'b1);
    idle(4);

    for (int i = 0; i < 8; i++) op(rnd_norm(100, 154), rnd_norm(100, 154));
    idle(4);

    op(rnd_norm(120, 130), rnd_norm(120, 130));
    op(rnd_norm(120, 130), rnd_norm(120, 130));
    rst_n = 1'b0;
    cyc(1'b1, 32'h3F800000, 32'h40000000, IDLE);
    rst_n = 1'b1;
    op_k(32'h3E800000, 32'h42C80000, 32'h42C88000, 1'b0, 1'b0);
    op(rnd_norm(100, 154), rnd_norm(100, 154));
    idle(4);

    for (int i = 0; i < 400; i++) begin
      sel = int'($urandom_range(15, 0));
      x   = rnd_norm(100, 154);
      y   = rnd_norm(100, 154);
      if (sel == 0) y = {~x[31], x[30:23], x[22:0] ^ 23'($urandom_range(7, 0))};
      if (sel == 1) y = sp[$urandom_range(5, 0)];
      if (sel == 2) begin x = rnd_norm(250, 254); y = rnd_norm(250, 254); end
      if (sel == 3) begin x = rnd_norm(1, 3); y = rnd_norm(1, 3); end
      if (sel == 4) y = {1'($urandom), x[30:23], 23'($urandom)};
      if (sel < 12) op(x, y);
      else cyc(1'b0, x, y, IDLE);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
